// File: rtl/v_mul_bist.sv
// v_mul_bist: built-in self-test sequencer for the v_mult_su SIMD multiplier
//   clk, rst (async, active-high), start (one-cycle run request)
//   mul_out          : multiplier result, sampled MUL_LAT cycles after an operand update
//   operand_a/b_reg  : operands driven to the multiplier
//   opcode_reg       : 00 mul, 01 mulh, 10 mulhu, 11 mulhsu
//   precision_reg    : 00 4x8-bit, 01 2x16-bit, 10 1x32-bit lanes
//   busy, done       : run status; done holds until the next start or reset
//   pass_cnt/fail_cnt: four saturating 16-bit counters, opcode k at [16k+15:16k]
//   err_valid        : a mismatch was seen in this run
//   fail_info        : first mismatch {opcode, precision, a, b, got}
module v_mul_bist #(
   parameter int unsigned MUL_LAT = 2,
   parameter int unsigned N_RAND = 16,
   parameter logic [31:0] SEED = 32'hACE12468
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] mul_out,
   output logic [31:0] operand_a_reg,
   output logic [31:0] operand_b_reg,
   output logic [1:0]  opcode_reg,
   output logic [1:0]  precision_reg,
   output logic        busy,
   output logic        done,
   output logic [63:0] pass_cnt,
   output logic [63:0] fail_cnt,
   output logic        err_valid,
   output logic [99:0] fail_info
);
   localparam logic [3:0] WAIT_LD = 4'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);
   localparam logic [8:0] V_LAST = 9'(35 + N_RAND);
   localparam logic [31:0] TAPS = 32'h80200003;
   typedef enum logic [2:0] {IDLE, LOAD, WAIT, CHECK, DONE} state_t;
   state_t state;
   logic [31:0] lfsr, lfsr_a, lfsr_b, gold, g8, g16, g32;
   logic [8:0] vcnt;
   logic [2:0] ci, cj;
   logic [1:0] nop, npr;
   logic [3:0] wcnt;
   logic sa, sb, hi, last_vec, miss;
   function automatic logic [31:0] corner(input logic [2:0] i);
      case (i)
         3'd0: return 32'h00000000;
         3'd1: return 32'hFFFFFFFF;
         3'd2: return 32'h01010101;
         3'd3: return 32'hF0F0F0F0;
         3'd4: return 32'hD2E4F0AF;
         default: return 32'h7F456010;
      endcase
   endfunction
   function automatic logic [31:0] step(input logic [31:0] x);
      return x[0] ? (x >> 1) ^ TAPS : x >> 1;
   endfunction
   // One lane of width w: operands extended to 64 bits so the low 2w bits of
   // the product are exact; (v ^ s) - s sign-extends a w-bit value.
   function automatic logic [31:0] lane(input logic [31:0] x, input logic [31:0] y,
                                        input logic sx, input logic sy, input logic h, input int w);
      logic [63:0] m, xe, ye, s, p;
      m = (64'd1 << w) - 64'd1;
      s = 64'd1 << (w - 1);
      xe = {32'd0, x} & m;
      ye = {32'd0, y} & m;
      xe = sx ? (xe ^ s) - s : xe;
      ye = sy ? (ye ^ s) - s : ye;
      p = xe * ye;
      return 32'((h ? p >> w : p) & m);
   endfunction
   assign lfsr_a = step(lfsr);
   assign lfsr_b = step(lfsr_a);
   assign sa = opcode_reg[0];
   assign sb = opcode_reg == 2'b01;
   assign hi = |opcode_reg;
   always_comb begin
      g8 = '0;
      g16 = '0;
      for (int k = 0; k < 4; k++)
         g8[8*k +: 8] = 8'(lane(32'(operand_a_reg[8*k +: 8]), 32'(operand_b_reg[8*k +: 8]), sa, sb, hi, 8));
      for (int k = 0; k < 2; k++)
         g16[16*k +: 16] = 16'(lane(32'(operand_a_reg[16*k +: 16]), 32'(operand_b_reg[16*k +: 16]), sa, sb, hi, 16));
      g32 = lane(operand_a_reg, operand_b_reg, sa, sb, hi, 32);
      gold = precision_reg == 2'b00 ? g8 : precision_reg == 2'b01 ? g16 : g32;
   end
   assign last_vec = vcnt == V_LAST;
   assign miss = mul_out != gold;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         lfsr <= SEED;
         {operand_a_reg, operand_b_reg, opcode_reg, precision_reg} <= '0;
         {busy, done, err_valid} <= '0;
         pass_cnt <= '0;
         fail_cnt <= '0;
         fail_info <= '0;
         {vcnt, ci, cj, nop, npr, wcnt} <= '0;
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               state <= LOAD;
               busy <= 1'b1;
               done <= 1'b0;
               err_valid <= 1'b0;
               pass_cnt <= '0;
               fail_cnt <= '0;
               fail_info <= '0;
               lfsr <= SEED;
               {vcnt, ci, cj, nop, npr} <= '0;
            end
            LOAD: begin
               opcode_reg <= nop;
               precision_reg <= npr;
               if (vcnt < 9'd36) begin
                  operand_a_reg <= corner(ci);
                  operand_b_reg <= corner(cj);
               end else begin
                  operand_a_reg <= lfsr_a;
                  operand_b_reg <= lfsr_b;
                  lfsr <= lfsr_b;
               end
               wcnt <= WAIT_LD;
               state <= MUL_LAT > 1 ? WAIT : CHECK;
            end
            WAIT: begin
               wcnt <= wcnt - 4'd1;
               state <= wcnt == 4'd0 ? CHECK : WAIT;
            end
            CHECK: begin
               if (miss) begin
                  if (fail_cnt[{opcode_reg, 4'b0} +: 16] != 16'hFFFF)
                     fail_cnt[{opcode_reg, 4'b0} +: 16] <= fail_cnt[{opcode_reg, 4'b0} +: 16] + 16'd1;
                  if (!err_valid) begin
                     err_valid <= 1'b1;
                     fail_info <= {opcode_reg, precision_reg, operand_a_reg, operand_b_reg, mul_out};
                  end
               end else if (pass_cnt[{opcode_reg, 4'b0} +: 16] != 16'hFFFF)
                  pass_cnt[{opcode_reg, 4'b0} +: 16] <= pass_cnt[{opcode_reg, 4'b0} +: 16] + 16'd1;
               vcnt <= last_vec ? 9'd0 : vcnt + 9'd1;
               cj <= last_vec || cj == 3'd5 ? 3'd0 : cj + 3'd1;
               ci <= last_vec ? 3'd0 : cj == 3'd5 ? ci + 3'd1 : ci;
               if (last_vec) begin
                  npr <= npr == 2'd2 ? 2'd0 : npr + 2'd1;
                  nop <= npr == 2'd2 ? nop + 2'd1 : nop;
               end
               if (last_vec && npr == 2'd2 && nop == 2'd3) begin
                  state <= DONE;
                  busy <= 1'b0;
                  done <= 1'b1;
               end else
                  state <= LOAD;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_v_mul_bist.sv
// tb_v_mul_bist: scoreboard bench for v_mul_bist with behavioural multipliers
module tb_v_mul_bist;
   localparam int LAT = 2;
   localparam int NR = 16;
   localparam int NV = 12 * (36 + NR);
   logic clk = 0, rst = 1, start1 = 0, start2 = 0, fault = 0;
   logic [31:0] mul1, mul2, a1, b1, a2, b2;
   logic [1:0] op1, pr1, op2, pr2;
   logic busy1, done1, busy2, done2, ev1, ev2;
   logic [63:0] pc1, fc1, pc2, fc2;
   logic [99:0] fi1, fi2;
   typedef struct packed {logic [1:0] op; logic [1:0] pr; logic [31:0] a; logic [31:0] b;} vec_t;
   vec_t exp_q[$];
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   v_mul_bist #(.MUL_LAT(LAT), .N_RAND(NR)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .mul_out(mul1),
      .operand_a_reg(a1), .operand_b_reg(b1), .opcode_reg(op1), .precision_reg(pr1),
      .busy(busy1), .done(done1), .pass_cnt(pc1), .fail_cnt(fc1),
      .err_valid(ev1), .fail_info(fi1));

   v_mul_bist #(.MUL_LAT(1), .N_RAND(0)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .mul_out(mul2),
      .operand_a_reg(a2), .operand_b_reg(b2), .opcode_reg(op2), .precision_reg(pr2),
      .busy(busy2), .done(done2), .pass_cnt(pc2), .fail_cnt(fc2),
      .err_valid(ev2), .fail_info(fi2));

   function automatic logic [31:0] model(input logic [1:0] op, input logic [1:0] pr,
                                         input logic [31:0] a, input logic [31:0] b);
      int w;
      logic [31:0] r;
      longint ua, ub, p, m;
      w = 8 << pr;
      r = '0;
      m = longint'((64'd1 << w) - 64'd1);
      for (int k = 0; k < 32 / w; k++) begin
         ua = longint'({32'd0, a} >> (k * w)) & m;
         ub = longint'({32'd0, b} >> (k * w)) & m;
         if (op[0] && ua[w-1]) ua = ua - longint'(64'd1 << w);
         if (op == 2'b01 && ub[w-1]) ub = ub - longint'(64'd1 << w);
         p = ua * ub;
         if (op != 2'b00) p = p >> w;
         r = r | 32'((p & m) << (k * w));
      end
      return r;
   endfunction

   function automatic logic [31:0] lnext(input logic [31:0] x);
      return x[0] ? (x >> 1) ^ 32'h80200003 : x >> 1;
   endfunction

   always @(posedge clk) mul1 <= model(op1, pr1, a1, b1) ^ {31'd0, fault && op1 == 2'b01};
   assign mul2 = model(op2, pr2, a2, b2);

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic build(input int nr);
      logic [31:0] s, x;
      logic [31:0] c [6];
      c = '{32'h00000000, 32'hFFFFFFFF, 32'h01010101, 32'hF0F0F0F0, 32'hD2E4F0AF, 32'h7F456010};
      s = 32'hACE12468;
      exp_q.delete();
      for (int op = 0; op < 4; op++)
         for (int pr = 0; pr < 3; pr++) begin
            for (int i = 0; i < 6; i++)
               for (int j = 0; j < 6; j++)
                  exp_q.push_back({2'(op), 2'(pr), c[i], c[j]});
            for (int r = 0; r < nr; r++) begin
               s = lnext(s);
               x = s;
               s = lnext(s);
               exp_q.push_back({2'(op), 2'(pr), x, s});
            end
         end
   endtask

   // monitor: one vector per LAT+1 cycles, loaded on the edge after each window start
   initial begin
      int ph;
      vec_t cur;
      ph = 0;
      cur = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!busy1) begin
            ph = 0;
            continue;
         end
         if (ph > 0 && (ph - 1) % (LAT + 1) == 0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL vec_extra got=%h exp=none", {op1, pr1, a1, b1});
            end else begin
               cur = exp_q.pop_front();
               chk("vec_load", {op1, pr1, a1, b1}, cur);
            end
         end else if (ph > 0 && (ph - 1) % (LAT + 1) == LAT - 1)
            chk("vec_hold", {op1, pr1, a1, b1}, cur);
         ph++;
      end
   end

   task automatic run1(input bit flt, input int sb, input int ra);
      int cyc;
      logic [63:0] ep, ef;
      fault = flt;
      build(NR);
      @(negedge clk) start1 = 1;
      @(negedge clk) start1 = 0;
      chk("start_busy", busy1, 1);
      chk("start_clear", {pc1, fc1, ev1, done1}, 0);
      cyc = 0;
      while (cyc < 3000) begin
         @(negedge clk);
         cyc++;
         start1 = cyc == sb;
         if (cyc == ra) begin
            #1 rst = 1;
            #1;
            chk("rst_ops", {a1, b1, op1, pr1}, 0);
            chk("rst_stat", {busy1, done1, ev1}, 0);
            chk("rst_cnt", {pc1, fc1}, 0);
            chk("rst_info", fi1, 0);
            #1 rst = 0;
            exp_q.delete();
            return;
         end
         if (done1) break;
      end
      start1 = 0;
      ep = {4{16'(NV / 4)}};
      ef = 0;
      if (flt) begin
         ep[31:16] = 0;
         ef[31:16] = 16'(NV / 4);
      end
      chk("run_cycles", cyc, NV * (LAT + 1));
      chk("end_status", {busy1, done1}, 2'b01);
      chk("pass_cnt", pc1, ep);
      chk("fail_cnt", fc1, ef);
      chk("err_valid", ev1, flt);
      chk("fail_info", fi1, flt ? {2'b01, 2'b00, 32'd0, 32'd0, 32'd1} : 100'd0);
      chk("hold_sel", {op1, pr1}, 4'b1110);
      chk("vec_left", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      chk("done_held", {busy1, done1}, 2'b01);
   endtask

   initial begin
      int cyc;
      repeat (3) @(negedge clk);
      chk("reset_ops", {a1, b1, op1, pr1}, 0);
      chk("reset_stat", {busy1, done1, ev1}, 0);
      chk("reset_cnt", {pc1, fc1}, 0);
      chk("reset_info", fi1, 0);
      rst = 0;
      chk("model_mul_8", model(2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'h01010101);
      chk("model_mulhu_8", model(2'b10, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFEFEFEFE);
      chk("model_mulhsu_8", model(2'b11, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
      chk("model_mulhu_16", model(2'b10, 2'b01, 32'hF0F0F0F0, 32'hF0F0F0F0), 32'hE2C2E2C2);
      chk("model_mulh_16", model(2'b01, 2'b01, 32'hF0F0F0F0, 32'hF0F0F0F0), 32'h00E200E2);
      run1(0, -1, -1);
      run1(0, 100, -1);
      run1(1, -1, -1);
      run1(0, -1, 500);
      repeat (2) @(negedge clk);
      run1(0, -1, -1);
      @(negedge clk) start2 = 1;
      @(negedge clk) start2 = 0;
      cyc = 0;
      while (cyc < 2000 && !done2) begin
         @(negedge clk);
         cyc++;
      end
      chk("lat1_cycles", cyc, 864);
      chk("lat1_pass", pc2, {4{16'd108}});
      chk("lat1_fail", {fc2, ev2}, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
